aer_spike_binner: RTL and testbench
===================================

// Module: aer_spike_binner
// PURPOSE
//  Consumes decoded AER events (channel_Id, timestamp, timestamp_valid) from the AER input
//  pipeline and bins them into per-channel spike counts over fixed timestamp windows.
//  Each closed window is emitted as one frame over a valid/ready handshake to the
//  neural core input buffer. The input side has no backpressure: one event per cycle is always accepted.
// PARAMETERS
//  NUM_CH     16    number of AER channels (= 2**CH_W)
//  CH_W       4     channel_Id width
//  TS_W       20    timestamp width; timestamp wraps modulo 2**TS_W
//  CNT_W      8     per-channel count width; counts saturate at 2**CNT_W-1
//  WIN_TICKS  1000  window length in timestamp ticks; must satisfy 1 <= WIN_TICKS < 2**(TS_W-1)
// PORTS
//  clk              in   1               system clock
//  rst_n            in   1               synchronous reset, active low
//  channel_Id       in   CH_W            event channel
//  timestamp        in   TS_W            event timestamp
//  timestamp_valid  in   1               event strobe, one event per asserted cycle
//  flush            in   1               force-close the current window (single-cycle pulse)
//  frame_valid      out  1               frame_data/frame_idx hold a frame
//  frame_ready      in   1               consumer accepts a frame when frame_valid && frame_ready
//  frame_data       out  NUM_CH*CNT_W    counts; channel c at [c*CNT_W +: CNT_W]
//  frame_idx        out  16              window sequence number, wraps 0xFFFF->0
//  frame_resync     out  1               frame was followed by a gap >= 2 windows (timebase resynced)
//  frame_drop       out  1               1-cycle pulse: a closed window was discarded
//  drop_count       out  16              saturating count of discarded frames
// BEHAVIOUR
//  Reset (rst_n=0 on a clk edge): state=IDLE, all counts 0, frame_valid=0, frame_data=0,
//   frame_idx=0, frame_resync=0, frame_drop=0, drop_count=0, ts_base=0, win_seq=0.
//   Reset mid-window discards the accumulating window and any held frame without a drop pulse.
//  IDLE: first timestamp_valid latches ts_base=timestamp, counts that event, goes to ACCUM.
//   flush in IDLE is ignored.
//  ACCUM: per event, delta = (timestamp - ts_base) mod 2**TS_W (unsigned, wrap-safe).
//   delta < WIN_TICKS        -> cnt[channel_Id] += 1, saturating.
//   WIN_TICKS <= delta < 2*WIN_TICKS -> close window; ts_base += WIN_TICKS (mod 2**TS_W);
//                                        resync flag of the closed frame = 0.
//   delta >= 2*WIN_TICKS     -> close window; ts_base = timestamp; resync flag = 1.
//   On close: the triggering event is counted as the sole event in the new window
//   (its channel count = 1, all other channels = 0).
//  flush in ACCUM (no event in the same cycle): close window, go to IDLE, counts cleared, resync=0.
//   flush and an event in the same cycle: flush wins. Close the window without counting the event,
//   then treat the event as the first event of IDLE (ts_base=timestamp, count 1, state ACCUM).
//  Close -> output: closed counts, win_seq and resync load into the holding register;
//   frame_valid rises the cycle after the closing event (latency 1); win_seq increments.
//   If the holding register is occupied and is not being accepted that cycle, the closed window is discarded:
//   frame_drop pulses, drop_count+1 (saturates at 0xFFFF), win_seq still increments.
//   Accept and close in the same cycle: the new frame loads and no drop occurs.
//  Handshake: frame_data/frame_idx/frame_resync stable while frame_valid && !frame_ready;
//   frame_valid drops the cycle after acceptance unless a new frame loads.
//  Counting never stalls. Saturation is per channel only.
// STRUCTURE
//  aer_pkg (shared): CH_W, TS_W, NUM_CH constants; aer_event_t {ch, ts};
//   function ts_delta(a,b) for modulo subtraction.
//  Sub-module aer_frame_holder: 1-entry valid/ready register carrying frame payload and drop logic.
//  Top holds the IDLE/ACCUM FSM, ts_base, count array and window comparator.
// TESTING  (WIN_TICKS=100 for the bench)
//  1 Reset, then events ch3@ts10, ch3@ts50, ch7@ts99, ch0@ts110 -> one frame: cnt3=2, cnt7=1,
//    others 0, idx=0, resync=0; frame_valid asserted the cycle after the ts110 event;
//    the next frame holds ch0=1.
//  2 300 events on ch5 within one window -> cnt5=255 (saturated), other channels 0.
//  3 Wrap: ts_base=0xFFFC0; event at ts 0x00010 (delta 0x50 < 100) -> counted in the same window;
//    event at ts 0x00030 (delta 0x70 >= 100) -> window closes, ts_base=0x00024.
//  4 Hold frame_ready=0; close two windows -> first frame held stable, frame_drop pulses once,
//    drop_count=1, next accepted frame has idx=0 then the following one idx=2.
//  5 Gap: base 0, next event at ts 450 -> frame resync=1, new ts_base=450;
//    flush together with an event -> window closed, event starts a new window.
//  6 Assert rst_n=0 mid-window with frame_valid=1 -> all outputs return to reset values next cycle;
//    no frame_drop pulse.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared AER definitions: channel/timestamp widths, event record and wrap-safe timestamp math.
package aer_pkg;

    localparam int unsigned CH_W   = 4;
    localparam int unsigned NUM_CH = 1 << CH_W;
    localparam int unsigned TS_W   = 20;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [TS_W-1:0] ts;
    } aer_event_t;

    // Distance from b forward to a, modulo the timestamp wrap.
    function automatic logic [TS_W-1:0] ts_delta(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/aer_frame_holder.sv
// One-entry valid/ready frame register; a closed window arriving while the entry is blocked is dropped.
module aer_frame_holder #(
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [15:0]       idx_i,
    input  logic              resync_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [15:0]       idx_o,
    output logic              resync_o,
    output logic              drop_o,
    output logic [15:0]       drop_count_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       idx_q, idx_d;
    logic              resync_q, resync_d;
    logic              drop_q, drop_d;
    logic [15:0]       drop_count_q, drop_count_d;
    logic              accept_c;
    logic              blocked_c;

    // An accept in the same cycle frees the entry, so only a stalled entry causes a drop.
    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        idx_d        = idx_q;
        resync_d     = resync_q;
        drop_d       = 1'b0;
        drop_count_d = drop_count_q;
        accept_c     = valid_q & ready_i;
        blocked_c    = load_i & valid_q & ~ready_i;

        if (load_i && !blocked_c) begin
            valid_d  = 1'b1;
            data_d   = data_i;
            idx_d    = idx_i;
            resync_d = resync_i;
        end else if (accept_c) begin
            valid_d = 1'b0;
        end

        if (blocked_c) begin
            drop_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            data_q       <= '0;
            idx_q        <= '0;
            resync_q     <= 1'b0;
            drop_q       <= 1'b0;
            drop_count_q <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            idx_q        <= idx_d;
            resync_q     <= resync_d;
            drop_q       <= drop_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign idx_o        = idx_q;
    assign resync_o     = resync_q;
    assign drop_o       = drop_q;
    assign drop_count_o = drop_count_q;

endmodule

// File: rtl/aer_spike_binner.sv
// Bins AER events into per-channel saturating spike counts over fixed timestamp windows.
module aer_spike_binner
    import aer_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned WIN_TICKS = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH_W-1:0]         channel_Id,
    input  logic [TS_W-1:0]         timestamp,
    input  logic                    timestamp_valid,
    input  logic                    flush,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [NUM_CH*CNT_W-1:0] frame_data,
    output logic [15:0]             frame_idx,
    output logic                    frame_resync,
    output logic                    frame_drop,
    output logic [15:0]             drop_count
);

    localparam logic [0:0]      S_IDLE  = 1'b0;
    localparam logic [0:0]      S_ACCUM = 1'b1;
    localparam logic [TS_W-1:0] WIN     = TS_W'(WIN_TICKS);
    localparam logic [TS_W-1:0] WIN2    = TS_W'(2 * WIN_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [TS_W-1:0]  ts_base_q, ts_base_d;
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic [15:0]      win_seq_q, win_seq_d;

    aer_event_t              ev_c;
    logic [TS_W-1:0]         delta_c;
    logic                    close_c;
    logic                    close_resync_c;
    logic [NUM_CH*CNT_W-1:0] closed_counts_c;

    assign ev_c    = '{ch: channel_Id, ts: timestamp};
    assign delta_c = ts_delta(ev_c.ts, ts_base_q);

    // Window FSM: a closing event always becomes the sole event of the next window.
    always_comb begin
        state_d        = state_q;
        ts_base_d      = ts_base_q;
        cnt_d          = cnt_q;
        close_c        = 1'b0;
        close_resync_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (timestamp_valid) begin
                    state_d   = S_ACCUM;
                    ts_base_d = ev_c.ts;
                    for (int c = 0; c < NUM_CH; c++) cnt_d[c] = '0;
                    cnt_d[ev_c.ch] = CNT_W'(1);
                end
            end
            S_ACCUM: begin
                if (flush) begin
                    close_c = 1'b1;
                    state_d = S_IDLE;
                    for (int c = 0; c < NUM_CH; c++) cnt_d[c] = '0;
                    if (timestamp_valid) begin
                        state_d        = S_ACCUM;
                        ts_base_d      = ev_c.ts;
                        cnt_d[ev_c.ch] = CNT_W'(1);
                    end
                end else if (timestamp_valid) begin
                    if (delta_c < WIN) begin
                        if (cnt_q[ev_c.ch] != CNT_MAX) begin
                            cnt_d[ev_c.ch] = cnt_q[ev_c.ch] + CNT_W'(1);
                        end
                    end else begin
                        close_c = 1'b1;
                        for (int c = 0; c < NUM_CH; c++) cnt_d[c] = '0;
                        cnt_d[ev_c.ch] = CNT_W'(1);
                        if (delta_c < WIN2) begin
                            ts_base_d = ts_base_q + WIN;
                        end else begin
                            ts_base_d      = ev_c.ts;
                            close_resync_c = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        win_seq_d = close_c ? win_seq_q + 16'd1 : win_seq_q;
    end

    always_comb begin
        closed_counts_c = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            closed_counts_c[c*CNT_W +: CNT_W] = cnt_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ts_base_q <= '0;
            win_seq_q <= '0;
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
        end else begin
            state_q   <= state_d;
            ts_base_q <= ts_base_d;
            win_seq_q <= win_seq_d;
            for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
        end
    end

    aer_frame_holder #(
        .DATA_W(NUM_CH * CNT_W)
    ) u_holder (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (close_c),
        .data_i      (closed_counts_c),
        .idx_i       (win_seq_q),
        .resync_i    (close_resync_c),
        .ready_i     (frame_ready),
        .valid_o     (frame_valid),
        .data_o      (frame_data),
        .idx_o       (frame_idx),
        .resync_o    (frame_resync),
        .drop_o      (frame_drop),
        .drop_count_o(drop_count)
    );

endmodule

// File: tb/tb_aer_spike_binner.sv
// Self-checking bench for aer_spike_binner: directed table, corner sequences and a random run vs a reference model.
module tb_aer_spike_binner;

    localparam int W    = 100;
    localparam int MASK = 'hFFFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   channel_Id = '0;
    logic [19:0]  timestamp = '0;
    logic         timestamp_valid = 1'b0;
    logic         flush = 1'b0;
    logic         frame_ready = 1'b0;
    logic         frame_valid;
    logic [127:0] frame_data;
    logic [15:0]  frame_idx;
    logic         frame_resync;
    logic         frame_drop;
    logic [15:0]  drop_count;

    int n_chk = 0;
    int n_fail = 0;

    aer_spike_binner #(.CNT_W(8), .WIN_TICKS(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .channel_Id     (channel_Id),
        .timestamp      (timestamp),
        .timestamp_valid(timestamp_valid),
        .flush          (flush),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .frame_data     (frame_data),
        .frame_idx      (frame_idx),
        .frame_resync   (frame_resync),
        .frame_drop     (frame_drop),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    // Reference model: window state, counts and the single output slot in plain integers.
    bit m_act, m_hv, m_hres, m_drop;
    int m_base, m_seq, m_hidx, m_dcnt;
    int m_cnt [16];
    int m_hdata [16];

    always @(posedge clk) begin : model
        int  d, ch, ts;
        bit  closed, cres, blocked;
        int  ccnt [16];
        if (!rst_n) begin
            m_act = 0; m_base = 0; m_seq = 0; m_hv = 0; m_hidx = 0;
            m_hres = 0; m_drop = 0; m_dcnt = 0;
            for (int c = 0; c < 16; c++) begin m_cnt[c] = 0; m_hdata[c] = 0; end
        end else begin
            ch = int'(channel_Id);
            ts = int'(timestamp);
            closed = 0; cres = 0;
            ccnt = m_cnt;
            if (!m_act) begin
                if (timestamp_valid) begin
                    m_act = 1; m_base = ts;
                    for (int c = 0; c < 16; c++) m_cnt[c] = 0;
                    m_cnt[ch] = 1;
                end
            end else if (flush) begin
                closed = 1;
                for (int c = 0; c < 16; c++) m_cnt[c] = 0;
                m_act = 0;
                if (timestamp_valid) begin
                    m_act = 1; m_base = ts; m_cnt[ch] = 1;
                end
            end else if (timestamp_valid) begin
                d = (ts - m_base) & MASK;
                if (d < W) begin
                    if (m_cnt[ch] < 255) m_cnt[ch] = m_cnt[ch] + 1;
                end else begin
                    closed = 1;
                    if (d < 2 * W) m_base = (m_base + W) & MASK;
                    else begin m_base = ts; cres = 1; end
                    for (int c = 0; c < 16; c++) m_cnt[c] = 0;
                    m_cnt[ch] = 1;
                end
            end
            m_drop = 0;
            blocked = m_hv && !frame_ready;
            if (closed) begin
                if (blocked) begin
                    m_drop = 1;
                    if (m_dcnt < 65535) m_dcnt = m_dcnt + 1;
                end else begin
                    m_hv = 1; m_hdata = ccnt; m_hidx = m_seq; m_hres = cres;
                end
                m_seq = (m_seq + 1) & 'hFFFF;
            end else if (m_hv && frame_ready) begin
                m_hv = 0;
            end
        end
    end

    function automatic logic [127:0] cv(input int ch, input int n);
        return 128'(n) << (ch * 8);
    endfunction

    function automatic logic [127:0] m_frame();
        logic [127:0] r = '0;
        for (int c = 0; c < 16; c++) r |= 128'(m_hdata[c]) << (c * 8);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, then compare every output with the model just after the edge.
    task automatic cyc(input bit v, input int ch, input int ts, input bit fl, input bit rdy);
        timestamp_valid = v;
        channel_Id      = 4'(ch);
        timestamp       = 20'(ts);
        flush           = fl;
        frame_ready     = rdy;
        @(posedge clk);
        #1;
        chk("model_valid", 128'(frame_valid), 128'(m_hv));
        chk("model_drop", 128'(frame_drop), 128'(m_drop));
        chk("model_drop_count", 128'(drop_count), 128'(m_dcnt));
        if (m_hv) begin
            chk("model_data", frame_data, m_frame());
            chk("model_idx", 128'(frame_idx), 128'(m_hidx));
            chk("model_resync", 128'(frame_resync), 128'(m_hres));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic exp_frame(input string nm, input bit fv, input logic [127:0] data,
                             input int idx, input bit res);
        chk({nm, "_valid"}, 128'(frame_valid), 128'(fv));
        chk({nm, "_data"}, frame_data, data);
        chk({nm, "_idx"}, 128'(frame_idx), 128'(idx));
        chk({nm, "_resync"}, 128'(frame_resync), 128'(res));
    endtask

    typedef struct {
        bit           v;
        int           ch;
        int           ts;
        bit           fl;
        bit           rdy;
        bit           exp_fv;
        logic [127:0] exp_data;
        int           exp_idx;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1, 3, 10,  0, 0, 0, '0, 0};
        tbl[1] = '{1, 3, 50,  0, 0, 0, '0, 0};
        tbl[2] = '{1, 7, 99,  0, 0, 0, '0, 0};
        tbl[3] = '{1, 0, 110, 0, 0, 1, cv(3, 2) | cv(7, 1), 0};
        tbl[4] = '{0, 0, 0,   0, 0, 1, cv(3, 2) | cv(7, 1), 0};
        tbl[5] = '{0, 0, 0,   0, 1, 0, '0, 0};
        tbl[6] = '{0, 0, 0,   1, 0, 1, cv(0, 1), 1};
        tbl[7] = '{0, 0, 0,   0, 1, 0, '0, 0};

        // Reset values
        cyc(0, 0, 0, 0, 0);
        do_reset();
        exp_frame("reset", 0, '0, 0, 0);
        chk("reset_drop", 128'(frame_drop), 0);
        chk("reset_drop_count", 128'(drop_count), 0);

        // Basic binning, latency 1, stability and acceptance
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].v, tbl[i].ch, tbl[i].ts, tbl[i].fl, tbl[i].rdy);
            chk($sformatf("t1_valid_%0d", i), 128'(frame_valid), 128'(tbl[i].exp_fv));
            if (tbl[i].exp_fv) begin
                chk($sformatf("t1_data_%0d", i), frame_data, tbl[i].exp_data);
                chk($sformatf("t1_idx_%0d", i), 128'(frame_idx), 128'(tbl[i].exp_idx));
            end
        end

        // Saturation
        do_reset();
        for (int i = 0; i < 300; i++) cyc(1, 5, 1000, 0, 0);
        cyc(0, 0, 0, 1, 0);
        exp_frame("sat", 1, cv(5, 255), 0, 0);

        // Timestamp wrap and base advance across the wrap
        do_reset();
        cyc(1, 1, 'hFFFC0, 0, 0);
        cyc(1, 2, 'h00010, 0, 0);
        chk("wrap_no_close", 128'(frame_valid), 0);
        cyc(1, 1, 'h00030, 0, 0);
        exp_frame("wrap_close", 1, cv(1, 1) | cv(2, 1), 0, 0);
        cyc(1, 4, 'h00087, 0, 1);
        chk("wrap_base_in", 128'(frame_valid), 0);
        cyc(1, 6, 'h00088, 0, 0);
        exp_frame("wrap_base_out", 1, cv(1, 1) | cv(4, 1), 1, 0);

        // Backpressure drop
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 100, 0, 0);
        exp_frame("bp_first", 1, cv(0, 1), 0, 0);
        chk("bp_no_drop", 128'(frame_drop), 0);
        cyc(1, 2, 200, 0, 0);
        exp_frame("bp_held", 1, cv(0, 1), 0, 0);
        chk("bp_drop_pulse", 128'(frame_drop), 1);
        chk("bp_drop_count", 128'(drop_count), 1);
        cyc(0, 0, 0, 0, 0);
        chk("bp_drop_end", 128'(frame_drop), 0);
        cyc(0, 0, 0, 0, 1);
        chk("bp_accepted", 128'(frame_valid), 0);
        cyc(1, 3, 300, 0, 0);
        exp_frame("bp_next", 1, cv(2, 1), 2, 0);

        // Gap resync, then flush together with an event
        do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(1, 2, 450, 0, 0);
        exp_frame("gap", 1, cv(1, 1), 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 3, 549, 0, 0);
        chk("gap_new_base", 128'(frame_valid), 0);
        cyc(1, 4, 560, 1, 0);
        exp_frame("flush_ev", 1, cv(2, 1) | cv(3, 1), 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        exp_frame("flush_after", 1, cv(4, 1), 2, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        chk("flush_idle_ignored", 128'(frame_valid), 0);

        // Reset mid-window with a held frame and a prior drop
        do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 100, 0, 0);
        cyc(1, 1, 200, 0, 0);
        chk("rst_pre_drop_count", 128'(drop_count), 1);
        rst_n = 1'b0;
        cyc(1, 1, 300, 0, 0);
        exp_frame("rst_mid", 0, '0, 0, 0);
        chk("rst_mid_drop", 128'(frame_drop), 0);
        chk("rst_mid_drop_count", 128'(drop_count), 0);
        rst_n = 1'b1;
        cyc(1, 5, 5000, 0, 0);
        chk("rst_restart", 128'(frame_valid), 0);
        cyc(0, 0, 0, 1, 0);
        exp_frame("rst_restart_frame", 1, cv(5, 1), 0, 0);

        // Random traffic against the model
        begin
            int cur_ts = 0;
            int r;
            bit burst;
            for (int i = 0; i < 4000; i++) begin
                burst = ((i / 400) % 3) == 1;
                r = int'($urandom_range(0, 99));
                if (burst) cur_ts = cur_ts + int'($urandom_range(0, 1));
                else if (r < 4) cur_ts = cur_ts + 250 + int'($urandom_range(0, 300));
                else if (r == 99) cur_ts = 'hFFFE0;
                else cur_ts = cur_ts + int'($urandom_range(0, 30));
                cur_ts = cur_ts & MASK;
                rst_n = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
                cyc(($urandom_range(0, 9) < 7),
                    burst ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 15)),
                    cur_ts,
                    ($urandom_range(0, 99) < 3),
                    ($urandom_range(0, 9) < 6));
            end
            rst_n = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
